// File: rtl/seg_scan_if.sv
// seg_scan_if: display-word load bus and scanned segment/digit outputs
//   master drives: load, value, dp_in, blank_lz
//   slave drives : S, dp, AN, frame_done
interface seg_scan_if #(
    parameter int NDIG = 4
);
    logic                  load;
    logic [4*NDIG-1:0]     value;
    logic [NDIG-1:0]       dp_in;
    logic                  blank_lz;
    logic [3:0]            S;
    logic                  dp;
    logic [NDIG-1:0]       AN;
    logic                  frame_done;

    modport master (
        output load, value, dp_in, blank_lz,
        input  S, dp, AN, frame_done
    );

    modport slave (
        input  load, value, dp_in, blank_lz,
        output S, dp, AN, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a multi-digit 7-segment display
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   bus.load       strobe capturing value/dp_in into the pending buffer
//   bus.value      hex digits, digit 0 rightmost
//   bus.dp_in      decimal point per digit
//   bus.blank_lz   leading-zero blanking enable
//   bus.S          nibble of the scanned digit, to the hex decoder
//   bus.dp         decimal point of the scanned digit
//   bus.AN         digit enables, polarity set by AN_ACTIVE_LOW
//   bus.frame_done one-cycle pulse when the scan wraps back to digit 0
module seg_scan_ctrl #(
    parameter int NDIG          = 4,
    parameter int DIV           = 50000,
    parameter int GAP           = 500,
    parameter int AN_ACTIVE_LOW = 1
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);
    localparam int CW = $clog2(DIV);
    localparam int DW = $clog2(NDIG);
    localparam logic [NDIG-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       dig_q, dig_d;
    logic [4*NDIG-1:0]   shadow_q, pend_q;
    logic [NDIG-1:0]     shadow_dp_q, pend_dp_q;
    logic                pend_flag_q;
    logic [3:0]          s_q;
    logic                dp_q;
    logic [NDIG-1:0]     an_q, an_d;
    logic                fd_q;
    logic                slot_end, wrap, lz_blank;
    logic [3:0]          nib;
    logic                nib_dp;
    logic [NDIG:0]       zero_hi;
    logic [NDIG-1:0]     en;

    always_comb begin
        slot_end = cnt_q == CW'(DIV - 1);
        wrap     = slot_end && dig_q == DW'(NDIG - 1);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        dig_d    = slot_end ? (wrap ? '0 : dig_q + 1'b1) : dig_q;
        state_d  = (cnt_d >= CW'(GAP)) ? DRIVE : BLANK;
        nib      = shadow_q[4*dig_q +: 4];
        nib_dp   = shadow_dp_q[dig_q];
        // zero_hi[k]: digit k and every digit above it are zero
        zero_hi[NDIG] = 1'b1;
        for (int k = NDIG - 1; k >= 0; k--)
            zero_hi[k] = zero_hi[k+1] && shadow_q[4*k +: 4] == 4'd0;
        lz_blank = bus.blank_lz && |dig_q && zero_hi[dig_q] && !nib_dp;
        en       = (state_q == DRIVE && !lz_blank) ? NDIG'(1) << dig_q : '0;
        an_d     = en ^ AN_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            dig_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_flag_q <= 1'b0;
            s_q         <= '0;
            dp_q        <= 1'b0;
            an_q        <= AN_OFF;
            fd_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            // outputs reflect the slot position held in cnt_q/state_q before this edge
            s_q     <= nib;
            dp_q    <= nib_dp;
            an_q    <= an_d;
            fd_q    <= wrap;
            if (wrap && pend_flag_q) begin
                shadow_q    <= pend_q;
                shadow_dp_q <= pend_dp_q;
                pend_flag_q <= 1'b0;
            end
            // a load on the commit edge lands after the commit and stays pending
            if (bus.load) begin
                pend_q      <= bus.value;
                pend_dp_q   <= bus.dp_in;
                pend_flag_q <= 1'b1;
            end
        end
    end

    assign bus.S          = s_q;
    assign bus.dp         = dp_q;
    assign bus.AN         = an_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl against a cycle-formula reference model
module tb_seg_scan_ctrl;
    localparam int NDIG = 4;
    localparam int DIV  = 8;
    localparam int GAP  = 2;

    typedef struct {
        logic [NDIG-1:0] an;
        logic [3:0]      s;
        logic            dp;
        logic            fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_scan_if #(.NDIG(NDIG)) bus ();

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP), .AN_ACTIVE_LOW(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t              q[$];
    int                n_chk = 0;
    int                n_fail = 0;
    int                n;
    logic [4*NDIG-1:0] shadow, pend;
    logic [NDIG-1:0]   shadow_dp, pend_dp;
    logic              pflag;

    task automatic cmp(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        n = 0;
        shadow = '0;
        shadow_dp = '0;
        pend = '0;
        pend_dp = '0;
        pflag = 1'b0;
    endtask

    // one clock: apply inputs, then predict outputs for this cycle from its index
    task automatic step(input logic l, input logic [4*NDIG-1:0] v, input logic [NDIG-1:0] p, input logic b);
        exp_t e;
        int pos, d;
        logic lz;
        bus.load = l;
        bus.value = v;
        bus.dp_in = p;
        bus.blank_lz = b;
        @(posedge clk);
        #1;
        pos = n % DIV;
        d = (n / DIV) % NDIG;
        e.s = 4'((shadow >> (4 * d)) & 'hF);
        e.dp = shadow_dp[d];
        lz = b && d > 0 && (shadow >> (4 * d)) == 0 && !shadow_dp[d];
        e.an = (pos < GAP || lz) ? '1 : ~(NDIG'(1) << d);
        e.fd = (pos == DIV - 1 && d == NDIG - 1);
        q.push_back(e);
        if (e.fd && pflag) begin
            shadow = pend;
            shadow_dp = pend_dp;
            pflag = 1'b0;
        end
        if (l) begin
            pend = v;
            pend_dp = p;
            pflag = 1'b1;
        end
        n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.load = 1'b0;
        #1;
        cmp("rst_AN", int'(bus.AN), 'hF);
        cmp("rst_S", int'(bus.S), 0);
        cmp("rst_dp", int'(bus.dp), 0);
        cmp("rst_fd", int'(bus.frame_done), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                cmp("AN", int'(bus.AN), int'(e.an));
                cmp("S", int'(bus.S), int'(e.s));
                cmp("dp", int'(bus.dp), int'(e.dp));
                cmp("frame_done", int'(bus.frame_done), int'(e.fd));
            end
        end
    end

    initial begin
        logic [4*NDIG-1:0] rv;
        bus.load = 1'b0;
        bus.value = '0;
        bus.dp_in = '0;
        bus.blank_lz = 1'b0;
        model_reset();
        do_reset();
        for (int c = 0; c < 100; c++) step(c == 5, 16'h12AF, 4'b0100, 1'b0);
        do_reset();
        for (int c = 0; c < 140; c++) step(c == 1 || c == 70, c < 70 ? 16'h0045 : 16'h0000, 4'b0000, 1'b1);
        do_reset();
        for (int c = 0; c < 70; c++) step(c == 10 || c == 20, c < 20 ? 16'h1111 : 16'h2222, 4'b0000, 1'b0);
        do_reset();
        for (int c = 0; c < 100; c++) step(c == 10 || c == 31, c < 31 ? 16'h1234 : 16'h3333, 4'b0000, 1'b0);
        do_reset();
        for (int c = 0; c <= 45; c++) step(c == 40, 16'h5555, 4'b0000, 1'b0);
        do_reset();
        for (int c = 0; c < 100; c++) step(1'b0, 16'h0000, 4'b0000, 1'b0);
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
            step($urandom_range(0, 9) == 0, rv, 4'($urandom_range(0, 3) == 0 ? $urandom : 0), 1'($urandom_range(0, 3) != 0));
        end
        bus.load = 1'b0;
        @(negedge clk);
        #1;
        cmp("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Holds a double-buffered display word and steps through the digits one at a time.
- Feeds each digit's nibble to the existing combinational hex-to-segment decoder (S in, D out) and drives the matching digit enable.
- Inserts a blanking gap between digits to suppress ghosting, optionally blanks leading zeros, and updates the displayed value only at frame boundaries, so there is no tearing.

Parameters:
- NDIG, 4, number of digits scanned; legal range 2..8.
- DIV, 50000, clock cycles per digit slot; must be >= 2.
- GAP, 500, blank cycles at the start of each slot; must satisfy 1 <= GAP < DIV.
- AN_ACTIVE_LOW, 1, 1 = enabled digit driven 0, 0 = enabled digit driven 1.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  single-cycle strobe that captures value/dp_in into the pending buffer.
- value  input  4*NDIG  hex digits; digit k = value[4k+3:4k]; digit 0 is rightmost.
- dp_in  input  NDIG  decimal point per digit, active-high.
- blank_lz  input  1  leading-zero blanking enable; sampled every cycle.
- S  output  4  nibble to the decoder; registered.
- dp  output  1  decimal point of the active digit, active-high; registered.
- AN  output  NDIG  digit enables, polarity set by AN_ACTIVE_LOW; registered.
- frame_done  output  1  one-cycle pulse on each frame wrap.

Behaviour:
- Reset (async, immediate):
  - cnt=0, dig=0, state=BLANK.
  - shadow and pending buffers = 0, pend_flag=0.
  - S=0, dp=0, frame_done=0, all AN inactive.
- Counting: cycle n = nth rising edge after rst deasserts, n from 0.
  - Slot counter cnt runs 0..DIV-1 and wraps.
  - FSM:
    - BLANK holds for cnt 0..GAP-1; all AN inactive.
    - BLANK -> DRIVE when cnt reaches GAP.
    - DRIVE holds for cnt GAP..DIV-1.
    - DRIVE -> BLANK at wrap; dig increments at the same time.
  - dig wraps NDIG-1 -> 0.
- Output timing: for cycles n in [s*DIV+GAP, s*DIV+DIV-1], AN enables digit dig=s mod NDIG only, S=shadow nibble[dig], dp=shadow_dp[dig]. In BLANK, S and dp keep the value of the upcoming digit and AN is all inactive.
- Leading-zero blanking: when blank_lz=1, any digit k>0 whose nibble and all higher nibbles are 0 and whose dp bit is 0 stays inactive in its DRIVE window. Digit 0 is never blanked. The slot still consumes DIV cycles.
- Load: on load=1, value/dp_in are written into pending and pend_flag is set. A later load overwrites pending; last load wins.
- Commit: on the edge where dig wraps NDIG-1 -> 0:
  - If pend_flag=1, shadow <= pending and pend_flag <= 0.
  - frame_done is high for that one cycle.
  - Digit 0 of the new frame shows the committed data.
- Simultaneous load and commit: the commit uses pending as it was before the edge. The new load data lands in pending and pend_flag stays 1, so it is shown next frame.
- Reset mid-frame: state returns to reset values immediately and the pending load is discarded.

Test Plan:
Bench parameters for all scenarios: NDIG=4, DIV=8, GAP=2, AN_ACTIVE_LOW=1.
1. Reset release with no load -> frame_done at cycle 31 and every 32 cycles after. AN=1111 on cycles 0-1 and 8-9. AN=1110 on cycles 2-7 with S=0. AN=1101 on cycles 10-15.
2. load with value=0x12AF, dp_in=0100 at cycle 5 -> no change until the wrap at cycle 31. Next frame: S=F (AN=1110), then A (1101), then 2 with dp=1 (1011), then 1 (0111).
3. blank_lz=1, committed value=0x0045 -> AN stays 1111 during the digit 3 and 2 DRIVE windows; digits 1/0 show 4/5. With value=0x0000, only digit 0 is enabled, S=0.
4. load 0x1111 at cycle 10, then load 0x2222 at cycle 20 -> frame from cycle 32 shows 2222.
5. load 0x3333 exactly on cycle 31, with 0x1234 pending from cycle 10 -> frame 1 shows 1234, frame 2 shows 3333.
6. Assert rst at cycle 45 for 1 cycle, with 0x5555 loaded at cycle 40 -> AN=1111, S=0, dp=0 immediately. Digit 0 is driven again at cycle 2 after release with S=0, and 5555 is never displayed.
